// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries the EX result, HI/LO request and memory-op
// descriptor into MEM, plus the madd/msub partial state that loops back to EX.
module ex_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,

    input  logic                ex_we,
    input  logic [ADDR_W-1:0]   ex_w_reg_addr,
    input  logic [DATA_W-1:0]   ex_w_data,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [OP_W-1:0]     ex_aluop,
    input  logic [DATA_W-1:0]   ex_mem_addr,
    input  logic [DATA_W-1:0]   ex_store_data,
    input  logic [2*DATA_W-1:0] hilo_temp_i,
    input  logic [1:0]          cnt_i,

    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_w_reg_addr,
    output logic [DATA_W-1:0]   mem_w_data,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [OP_W-1:0]     mem_aluop,
    output logic [DATA_W-1:0]   mem_mem_addr,
    output logic [DATA_W-1:0]   mem_store_data,
    output logic [2*DATA_W-1:0] hilo_temp_o,
    output logic [1:0]          cnt_o
);

    logic ex_stall;
    logic mem_stall;

    assign ex_stall  = stall[3];
    assign mem_stall = stall[4];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; omitting an assignment in a branch means "hold".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we         <= 1'b0;
            mem_w_reg_addr <= '0;
            mem_w_data     <= '0;
            mem_whilo      <= 1'b0;
            mem_hi         <= '0;
            mem_lo         <= '0;
            mem_aluop      <= '0;
            mem_mem_addr   <= '0;
            mem_store_data <= '0;
            hilo_temp_o    <= '0;
            cnt_o          <= '0;
        end else if (flush) begin
            mem_we         <= 1'b0;
            mem_w_reg_addr <= '0;
            mem_w_data     <= '0;
            mem_whilo      <= 1'b0;
            mem_hi         <= '0;
            mem_lo         <= '0;
            mem_aluop      <= '0;
            mem_mem_addr   <= '0;
            mem_store_data <= '0;
            hilo_temp_o    <= '0;
            cnt_o          <= '0;
        end else if (ex_stall && !mem_stall) begin
            // EX stalls while MEM moves on: insert a bubble, keep the madd/msub state.
            mem_we         <= 1'b0;
            mem_w_reg_addr <= '0;
            mem_w_data     <= '0;
            mem_whilo      <= 1'b0;
            mem_hi         <= '0;
            mem_lo         <= '0;
            mem_aluop      <= '0;
            mem_mem_addr   <= '0;
            mem_store_data <= '0;
            hilo_temp_o    <= hilo_temp_i;
            cnt_o          <= cnt_i;
        end else if (!ex_stall) begin
            // The illegal vector (EX running, MEM stalled) lands here as a plain advance.
            mem_we         <= ex_we;
            mem_w_reg_addr <= ex_w_reg_addr;
            mem_w_data     <= ex_w_data;
            mem_whilo      <= ex_whilo;
            mem_hi         <= ex_hi;
            mem_lo         <= ex_lo;
            mem_aluop      <= ex_aluop;
            mem_mem_addr   <= ex_mem_addr;
            mem_store_data <= ex_store_data;
            hilo_temp_o    <= '0;
            cnt_o          <= '0;
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed scenarios followed by randomized
// traffic compared against a field-level reference model of the stage rules.
module tb_ex_mem;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 8;

    typedef struct packed {
        logic                we;
        logic [ADDR_W-1:0]   waddr;
        logic [DATA_W-1:0]   wdata;
        logic                whilo;
        logic [DATA_W-1:0]   hi;
        logic [DATA_W-1:0]   lo;
        logic [OP_W-1:0]     aluop;
        logic [DATA_W-1:0]   maddr;
        logic [DATA_W-1:0]   sdata;
        logic [2*DATA_W-1:0] temp;
        logic [1:0]          cnt;
    } out_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [5:0]          stall;
    logic                flush;
    logic                ex_we;
    logic [ADDR_W-1:0]   ex_w_reg_addr;
    logic [DATA_W-1:0]   ex_w_data;
    logic                ex_whilo;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic [OP_W-1:0]     ex_aluop;
    logic [DATA_W-1:0]   ex_mem_addr;
    logic [DATA_W-1:0]   ex_store_data;
    logic [2*DATA_W-1:0] hilo_temp_i;
    logic [1:0]          cnt_i;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_w_reg_addr;
    logic [DATA_W-1:0]   mem_w_data;
    logic                mem_whilo;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic [OP_W-1:0]     mem_aluop;
    logic [DATA_W-1:0]   mem_mem_addr;
    logic [DATA_W-1:0]   mem_store_data;
    logic [2*DATA_W-1:0] hilo_temp_o;
    logic [1:0]          cnt_o;

    int   n_checks = 0;
    int   n_errors = 0;
    logic allow_illegal = 1'b0;
    out_t model;

    ex_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_we(ex_we), .ex_w_reg_addr(ex_w_reg_addr), .ex_w_data(ex_w_data),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
        .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_we(mem_we), .mem_w_reg_addr(mem_w_reg_addr), .mem_w_data(mem_w_data),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_store_data(mem_store_data),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // Stall vectors with EX running but MEM stalled are only driven on purpose.
    always @(posedge clk) begin
        if (!rst) begin
            assert (allow_illegal || !(stall[4] && !stall[3]))
                else $error("illegal stall vector %b", stall);
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic out_t dut_out();
        return '{mem_we, mem_w_reg_addr, mem_w_data, mem_whilo, mem_hi, mem_lo,
                 mem_aluop, mem_mem_addr, mem_store_data, hilo_temp_o, cnt_o};
    endfunction

    // Reference: what the stage must hold after one edge, given current inputs.
    function automatic out_t model_next(input out_t cur);
        out_t nxt;
        nxt = cur;
        if (flush) begin
            nxt = '0;
        end else if (!stall[3]) begin
            nxt = '{ex_we, ex_w_reg_addr, ex_w_data, ex_whilo, ex_hi, ex_lo,
                    ex_aluop, ex_mem_addr, ex_store_data, '0, 2'd0};
        end else if (!stall[4]) begin
            nxt = '0;
            nxt.temp = hilo_temp_i;
            nxt.cnt  = cnt_i;
        end
        return nxt;
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        model = rst ? '0 : model_next(model);
        #1;
        check(tag, 256'(dut_out()), 256'(model));
    endtask

    task automatic clear_ex();
        {ex_we, ex_w_reg_addr, ex_w_data, ex_whilo, ex_hi, ex_lo} = '0;
        {ex_aluop, ex_mem_addr, ex_store_data, hilo_temp_i, cnt_i} = '0;
    endtask

    task automatic rand_ex();
        ex_we         = 1'($urandom);
        ex_w_reg_addr = ADDR_W'($urandom);
        ex_w_data     = $urandom;
        ex_whilo      = 1'($urandom);
        ex_hi         = $urandom;
        ex_lo         = $urandom;
        ex_aluop      = OP_W'($urandom);
        ex_mem_addr   = $urandom;
        ex_store_data = $urandom;
        hilo_temp_i   = {$urandom, $urandom};
        cnt_i         = 2'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        stall = '0;
        flush = 1'b0;
        model = '0;
        rand_ex();
        #1;
        check("reset_immediate", 256'(dut_out()), 256'(0));
        tick("reset_held");
        rst = 1'b0;

        // Plain advance with a register write.
        clear_ex();
        ex_we = 1'b1; ex_w_reg_addr = 5'd3; ex_w_data = 32'h0000_F0F0;
        tick("advance");
        check("advance_we", 256'(mem_we), 256'(1));
        check("advance_addr", 256'(mem_w_reg_addr), 256'(3));
        check("advance_data", 256'(mem_w_data), 256'(32'h0000_F0F0));
        check("advance_cnt", 256'(cnt_o), 256'(0));

        // Bubble keeps the multi-cycle state, then an advance clears it.
        stall = 6'b001111; cnt_i = 2'd1; hilo_temp_i = 64'h1_0000_0002;
        tick("bubble");
        check("bubble_we", 256'(mem_we), 256'(0));
        check("bubble_data", 256'(mem_w_data), 256'(0));
        check("bubble_cnt", 256'(cnt_o), 256'(1));
        check("bubble_temp", 256'(hilo_temp_o), 256'(64'h1_0000_0002));
        stall = '0; rand_ex();
        tick("bubble_release");
        check("release_cnt", 256'(cnt_o), 256'(0));
        check("release_data", 256'(mem_w_data), 256'(ex_w_data));

        // Hold for three cycles while EX keeps changing.
        clear_ex(); ex_w_data = 32'hDEAD_BEEF;
        tick("hold_load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            tick("hold");
            check("hold_data", 256'(mem_w_data), 256'(32'hDEAD_BEEF));
        end

        // Flush wins over a full stall.
        flush = 1'b1;
        tick("flush_over_stall");
        check("flush_all_zero", 256'(dut_out()), 256'(0));
        flush = 1'b0;

        // HI/LO path.
        stall = '0; clear_ex();
        ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
        tick("hilo");
        check("hilo_vals", 256'({mem_whilo, mem_hi, mem_lo}), 256'({1'b1, 32'h1, 32'h2}));

        // Async reset between edges while mem_we is set, then release with stall=0.
        ex_we = 1'b1;
        tick("pre_reset_adv");
        #2 rst = 1'b1;
        #1;
        check("async_rst_we", 256'(mem_we), 256'(0));
        model = '0;
        tick("rst_held");
        rst = 1'b0; stall = '0; rand_ex();
        tick("post_reset_capture");

        // Reset mid-bubble / mid-hold discards the captured state.
        stall = 6'b001000; rand_ex(); cnt_i = 2'd2;
        tick("bubble_before_rst");
        stall = 6'b011000;
        tick("hold_before_rst");
        #2 rst = 1'b1;
        #1;
        model = '0;
        check("rst_mid_hold", 256'(dut_out()), 256'(0));
        tick("rst_mid_hold_edge");
        rst = 1'b0;

        // The illegal vector behaves as an advance; ignored bits have no effect.
        allow_illegal = 1'b1;
        stall = 6'b010000; rand_ex();
        tick("illegal_as_advance");
        stall = 6'b100111; rand_ex();
        tick("ignored_bits");
        allow_illegal = 1'b0;

        // Randomized traffic, including occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            rand_ex();
            stall = 6'($urandom);
            if (stall[4] && !stall[3]) stall[3] = 1'b1;
            flush = ($urandom_range(7) == 0);
            if ($urandom_range(31) == 0) begin
                rst = 1'b1;
                #2;
                model = '0;
                check("rand_async_rst", 256'(dut_out()), 256'(0));
                tick("rand_rst_edge");
                rst = 1'b0;
            end else begin
                tick("random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the data, HI/LO, address and store-data fields.
REQ-002 Parameter ADDR_W, default 5, SHALL set the width of the destination register address.
REQ-003 Parameter OP_W, default 8, SHALL set the width of the ALU op code forwarded to MEM.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 stall  in  6  SHALL be the pipeline stall vector; bit 3 means EX stalled and bit 4 means MEM stalled.
REQ-007 flush  in  1  SHALL be the synchronous pipeline flush request.
REQ-008 ex_we, ex_w_reg_addr[ADDR_W], ex_w_data[DATA_W]  in  SHALL be the EX register-write result.
REQ-009 ex_whilo, ex_hi[DATA_W], ex_lo[DATA_W]  in  SHALL be the EX HI/LO write request and values.
REQ-010 ex_aluop[OP_W], ex_mem_addr[DATA_W], ex_store_data[DATA_W]  in  SHALL be the memory-op descriptor.
REQ-011 hilo_temp_i[2*DATA_W], cnt_i[2]  in  SHALL be the EX multi-cycle (madd/msub) partial product and its cycle count.
REQ-012 mem_we, mem_w_reg_addr, mem_w_data, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_store_data  out  SHALL be the registered copies of the corresponding ex_* inputs, with matching widths.
REQ-013 hilo_temp_o[2*DATA_W], cnt_o[2]  out  SHALL be the registered multi-cycle state fed back to EX.

Function
REQ-014 The block SHALL be a single-stage register with 1-cycle latency from ex_* to mem_*; it SHALL contain no combinational path from any input to any output.
REQ-015 Update priority on each rising edge SHALL be: flush, then bubble, then advance, then hold.
REQ-016 flush=1 SHALL clear every mem_* output, hilo_temp_o and cnt_o to 0, regardless of stall.
REQ-017 Bubble (flush=0, stall[3]=1, stall[4]=0) SHALL clear every mem_* output to 0, so that mem_we=0 and mem_whilo=0, and SHALL load hilo_temp_o<=hilo_temp_i and cnt_o<=cnt_i.
REQ-018 Advance (flush=0, stall[3]=0) SHALL load every mem_* output from its ex_* input and SHALL clear hilo_temp_o and cnt_o to 0.
REQ-019 Hold (flush=0, stall[3]=1, stall[4]=1) SHALL leave every output unchanged.
REQ-020 stall[3]=0 with stall[4]=1 is an illegal vector; the block SHALL treat it as advance, and the bench SHALL flag it as an assertion.
REQ-021 Bits 0-2 and 5 of stall SHALL be ignored.
REQ-022 cnt_o SHALL only ever hold a value captured from cnt_i or 0; the block SHALL perform no arithmetic on it.

Reset
REQ-023 While rst=1, all outputs SHALL be 0 immediately, without waiting for a clock edge, and SHALL stay 0.
REQ-024 The first rising edge after rst falls SHALL follow REQ-015 normally.
REQ-025 Reset asserted mid-bubble or mid-hold SHALL discard the captured hilo_temp_o/cnt_o and all mem_* contents.

Verification
REQ-026 Advance: stall=0, ex_we=1, ex_w_reg_addr=5'd3, ex_w_data=32'h0000_F0F0 -> next edge mem_we=1, mem_w_reg_addr=3, mem_w_data=32'h0000_F0F0, cnt_o=0.
REQ-027 Bubble: stall=6'b001111, ex_we=1, cnt_i=2'd1, hilo_temp_i=64'h1_0000_0002 -> next edge mem_we=0, mem_w_data=0, cnt_o=1, hilo_temp_o=64'h1_0000_0002; then stall=0 -> cnt_o=0 and mem_* track ex_*.
REQ-028 Hold: load mem_w_data=32'hDEAD_BEEF, then stall=6'b011111 for 3 cycles with changing ex_* -> mem_w_data stays 32'hDEAD_BEEF throughout.
REQ-029 Flush priority: stall=6'b011111 and flush=1 in the same cycle -> all outputs 0 after the edge.
REQ-030 Async reset: assert rst between clock edges while mem_we=1 -> mem_we=0 before the next edge; release rst with stall=0 -> first edge captures ex_*.
REQ-031 HI/LO path: ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2, stall=0 -> mem_whilo=1, mem_hi=1, mem_lo=2 after one edge.
